// File: rtl/wb_slave_mem_pkg.sv
// Wishbone cycle/burst type constants, slave FSM states and the
// shared burst next-address helper used by master and slave sides.
package wb_slave_mem_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  localparam int ADR_W = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CLASSIC,
    S_BURST,
    S_ERR
  } state_t;

  // Wrapping bursts only advance the bits below the wrap boundary.
  function automatic logic [ADR_W-1:0] wb_next_adr(
    input logic [ADR_W-1:0] adr,
    input logic [2:0]       cti,
    input logic [1:0]       bte,
    input int               dw
  );
    logic [ADR_W-1:0] inc;
    logic [ADR_W-1:0] mask;
    logic [ADR_W-1:0] sum;
    inc = ADR_W'(dw / 8);
    case (bte)
      BTE_WRAP4:  mask = (inc << 2) - ADR_W'(1);
      BTE_WRAP8:  mask = (inc << 3) - ADR_W'(1);
      BTE_WRAP16: mask = (inc << 4) - ADR_W'(1);
      default:    mask = '1;
    endcase
    sum = adr + inc;
    if (cti == CTI_CONST) return adr;
    return (adr & ~mask) | (sum & mask);
  endfunction

endpackage

// File: rtl/wb_slave_mem_ram.sv
// Single-port word RAM: per-byte synchronous write, async read.
// MEMFILE kept for interface compatibility; no preload performed.
module wb_slave_mem_ram #(
  parameter int    DW      = 32,
  parameter int    DEPTH   = 256,
  parameter string MEMFILE = ""
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [DW/8-1:0]          sel,
  input  logic [$clog2(DEPTH)-1:0] adr,
  input  logic [DW-1:0]            wdat,
  output logic [DW-1:0]            rdat
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < DW / 8; b++) begin
      if (we && sel[b]) mem[adr][8*b +: 8] <= wdat[8*b +: 8];
    end
  end

  assign rdat = mem[adr];

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone B3 memory slave with classic and burst cycles.
// Define WB_SLAVE_MEM_WAIT_EN to insert WAIT_STATES before the first ack.
module wb_slave_mem
  import wb_slave_mem_pkg::*;
#(
  parameter int             aw          = 32,
  parameter int             dw          = 32,
  parameter int             DEPTH       = 256,
  parameter logic [aw-1:0]  BASE_ADR    = '0,
  parameter int             WAIT_STATES = 2,
  parameter string          MEMFILE     = ""
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [aw-1:0]   wb_adr_i,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic [dw/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [dw-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);

  localparam int SH = $clog2(dw / 8);
  localparam int IW = $clog2(DEPTH);

  state_t state, state_nx, tgt;

  logic          req, hit, match, last;
  logic          beat, enter, ram_we;
  logic [aw:0]   diff;
  logic [aw-1:0] idx, nxt, pred;
  logic [IW-1:0] cidx, nidx, ram_adr;
  logic [dw-1:0] ram_rd;

  assign req   = wb_cyc_i & wb_stb_i;
  assign diff  = {1'b0, wb_adr_i} - {1'b0, BASE_ADR};
  assign idx   = diff[aw-1:0] >> SH;
  assign hit   = !diff[aw] && (idx < aw'(DEPTH));
  assign cidx  = IW'(idx);
  assign nxt   = aw'(wb_next_adr(ADR_W'(wb_adr_i),
                   wb_cti_i, wb_bte_i, dw));
  assign nidx  = IW'((nxt - BASE_ADR) >> SH);
  assign match = wb_adr_i == pred;
  assign last  = !(wb_cti_i == CTI_CONST ||
                   wb_cti_i == CTI_INC);
  assign tgt   = !hit ? S_ERR :
                 (last ? S_CLASSIC : S_BURST);

  assign beat     = (state == S_BURST) && req && match;
  assign wb_ack_o = req && ((state == S_CLASSIC) ||
                            (beat && hit));
  assign wb_err_o = req && ((state == S_ERR) ||
                            (beat && !hit));
  assign wb_rty_o = 1'b0;

  // Read bursts fetch the predicted next word so it is ready next beat
  assign ram_we  = wb_ack_o && wb_we_i;
  assign ram_adr = (state == S_BURST && !wb_we_i) ? nidx : cidx;
  assign enter   = (state_nx == S_CLASSIC) ||
                   (state_nx == S_BURST && state != S_BURST);

`ifdef WB_SLAVE_MEM_WAIT_EN
  localparam int CW = $clog2(WAIT_STATES + 1);
  logic [CW-1:0] cnt;

  // Wait-state countdown from decode to first response
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      cnt <= '0;
    else if (state == S_IDLE && state_nx == S_WAIT)
      cnt <= CW'(WAIT_STATES - 1);
    else if (state == S_WAIT && cnt != '0)
      cnt <= cnt - CW'(1);
  end
`endif

  // FSM state register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (req) begin
`ifdef WB_SLAVE_MEM_WAIT_EN
          state_nx = S_WAIT;
`else
          state_nx = tgt;
`endif
        end
      end
`ifdef WB_SLAVE_MEM_WAIT_EN
      S_WAIT: begin
        if (!req)           state_nx = S_IDLE;
        else if (cnt == '0) state_nx = tgt;
      end
`endif
      S_BURST: begin
        if (!wb_ack_o || last) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Predicted burst address and registered read data
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pred     <= '0;
      wb_dat_o <= '0;
    end else if (enter) begin
      pred     <= wb_adr_i;
      wb_dat_o <= ram_rd;
    end else if (state == S_BURST && wb_ack_o) begin
      pred     <= nxt;
      wb_dat_o <= ram_rd;
    end
  end

  wb_slave_mem_ram #(
    .DW      (dw),
    .DEPTH   (DEPTH),
    .MEMFILE (MEMFILE)
  ) u_ram (
    .clk  (wb_clk_i),
    .we   (ram_we),
    .sel  (wb_sel_i),
    .adr  (ram_adr),
    .wdat (wb_dat_i),
    .rdat (ram_rd)
  );

endmodule

// File: tb/tb_wb_slave_mem.sv
// Directed bench for wb_slave_mem: classic, byte-select, bursts,
// window errors and reset during a burst.
module tb_wb_slave_mem;

  localparam int WS = 2;
`ifdef WB_SLAVE_MEM_WAIT_EN
  localparam int LAT = 1 + WS;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr, dat, dat_o;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack, err, rty;

  logic [31:0] b_adr [8];
  logic [31:0] b_dat [8];
  logic [31:0] r_dat [8];
  logic        r_ack [8];
  logic        r_err [8];
  int          r_n, b_lat;
  logic        tail_ack;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  wb_slave_mem #(
    .aw          (32),
    .dw          (32),
    .DEPTH       (256),
    .BASE_ADR    (32'h0),
    .WAIT_STATES (WS),
    .MEMFILE     ("")
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_adr_i (adr),
    .wb_dat_i (dat),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_cti_i (cti),
    .wb_bte_i (bte),
    .wb_dat_o (dat_o),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .wb_rty_o (rty)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic classic(input  logic [31:0] a,
                         input  logic        w,
                         input  logic [31:0] d,
                         input  logic [3:0]  s,
                         output logic        k,
                         output logic        e,
                         output int          lat,
                         output logic [31:0] q,
                         output logic        k2);
    @(posedge clk); #1;
    adr = a; dat = d; sel = s; we = w;
    cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!(ack || err) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    k = ack; e = err; q = dat_o;
    chk("ack_err_excl", 32'(ack & err), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    k2 = ack;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic burst(input logic       w,
                       input int         n,
                       input logic [2:0] ct,
                       input logic [1:0] bt,
                       input int         rb);
    int   lat;
    logic ok;
    r_n = 0; b_lat = -1; tail_ack = 1'bx;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; bte = bt; sel = 4'hF;
    for (int i = 0; i < n; i++) begin
      adr = b_adr[i]; dat = b_dat[i];
      cti = (i == n - 1) ? 3'b111 : ct;
      if (i == rb) begin
        #2;
        rst = 1'b1;
      end
      @(negedge clk);
      if (i == 0) begin
        lat = 0;
        while (!(ack || err) && lat < 20) begin
          @(negedge clk);
          lat++;
        end
        b_lat = lat;
      end
      r_ack[i] = ack; r_err[i] = err; r_dat[i] = dat_o;
      r_n = i + 1;
      if (!ack || err || i == n - 1 || i == rb) break;
      @(posedge clk); #1;
    end
    ok = (r_n == n) && r_ack[n-1];
    @(posedge clk); #1;
    if (ok) begin
      we = 1'b0; cti = 3'b111; adr = b_adr[n-1] + 32'h4;
      @(negedge clk);
      tail_ack = ack;
      @(posedge clk); #1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic        k, e, k2;
    int          lat;
    logic [31:0] q;
    logic [31:0] wrap_exp [4];

    adr = '0; dat = '0; sel = '0; we = 1'b0;
    cyc = 1'b0; stb = 1'b0; cti = '0; bte = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_rty", 32'(rty), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    classic(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, k, e, lat, q, k2);
    chk("cw_ack", 32'(k), 32'd1);
    classic(32'h10, 1'b0, 32'h0, 4'hF, k, e, lat, q, k2);
    chk("cr_lat", 32'(lat), 32'(LAT));
    chk("cr_ack", 32'(k), 32'd1);
    chk("cr_dat", q, 32'hDEADBEEF);
    chk("cr_1cyc", 32'(k2), 32'd0);

    classic(32'h14, 1'b1, 32'h11223344, 4'hF, k, e, lat, q, k2);
    classic(32'h14, 1'b1, 32'h0000AB00, 4'h2, k, e, lat, q, k2);
    chk("sel_wr_ack", 32'(k), 32'd1);
    classic(32'h14, 1'b0, 32'h0, 4'hF, k, e, lat, q, k2);
    chk("sel_dat", q, 32'h1122AB44);

    for (int i = 0; i < 8; i++) begin
      b_adr[i] = 32'h20 + 32'(4 * i);
      b_dat[i] = 32'(i);
    end
    burst(1'b1, 8, 3'b010, 2'b00, -1);
    chk("bw_beats", 32'(r_n), 32'd8);
    chk("bw_last_ack", 32'(r_ack[7]), 32'd1);
    chk("bw_tail", 32'(tail_ack), 32'd0);
    burst(1'b0, 8, 3'b010, 2'b00, -1);
    chk("br_lat", 32'(b_lat), 32'(LAT));
    chk("br_beats", 32'(r_n), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("br_ack", 32'(r_ack[i]), 32'd1);
      chk("br_dat", r_dat[i], 32'(i));
    end
    chk("br_tail", 32'(tail_ack), 32'd0);

    b_adr[0] = 32'h38; b_adr[1] = 32'h3C;
    b_adr[2] = 32'h30; b_adr[3] = 32'h34;
    wrap_exp[0] = 32'd6; wrap_exp[1] = 32'd7;
    wrap_exp[2] = 32'd4; wrap_exp[3] = 32'd5;
    burst(1'b0, 4, 3'b010, 2'b01, -1);
    chk("wrap_beats", 32'(r_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_ack", 32'(r_ack[i]), 32'd1);
      chk("wrap_dat", r_dat[i], wrap_exp[i]);
    end
    chk("wrap_tail", 32'(tail_ack), 32'd0);

    classic(32'h400, 1'b0, 32'h0, 4'hF, k, e, lat, q, k2);
    chk("miss_err", 32'(e), 32'd1);
    chk("miss_ack", 32'(k), 32'd0);
    chk("miss_lat", 32'(lat), 32'(LAT));

    b_adr[0] = 32'h3FC; b_adr[1] = 32'h400;
    burst(1'b0, 2, 3'b010, 2'b00, -1);
    chk("edge_n", 32'(r_n), 32'd2);
    chk("edge_b0_ack", 32'(r_ack[0]), 32'd1);
    chk("edge_b0_err", 32'(r_err[0]), 32'd0);
    chk("edge_b1_ack", 32'(r_ack[1]), 32'd0);
    chk("edge_b1_err", 32'(r_err[1]), 32'd1);

    classic(32'h8C, 1'b1, 32'h55555555, 4'hF, k, e, lat, q, k2);
    classic(32'h90, 1'b1, 32'h55555555, 4'hF, k, e, lat, q, k2);
    for (int i = 0; i < 8; i++) begin
      b_adr[i] = 32'h80 + 32'(4 * i);
      b_dat[i] = 32'hA0 + 32'(i);
    end
    burst(1'b1, 8, 3'b010, 2'b00, 3);
    chk("rst_n", 32'(r_n), 32'd4);
    for (int i = 0; i < 3; i++)
      chk("rst_pre_ack", 32'(r_ack[i]), 32'd1);
    chk("rst_b3_ack", 32'(r_ack[3]), 32'd0);
    chk("rst_b3_err", 32'(r_err[3]), 32'd0);
    classic(32'h80, 1'b0, 32'h0, 4'hF, k, e, lat, q, k2);
    chk("post_rst_ack", 32'(k), 32'd1);
    chk("post_w0", q, 32'hA0);
    classic(32'h84, 1'b0, 32'h0, 4'hF, k, e, lat, q, k2);
    chk("post_w1", q, 32'hA1);
    classic(32'h88, 1'b0, 32'h0, 4'hF, k, e, lat, q, k2);
    chk("post_w2", q, 32'hA2);
    classic(32'h8C, 1'b0, 32'h0, 4'hF, k, e, lat, q, k2);
    chk("post_w3", q, 32'h55555555);
    classic(32'h90, 1'b0, 32'h0, 4'hF, k, e, lat, q, k2);
    chk("post_w4", q, 32'h55555555);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
